// File: rtl/line_window_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_window_pkg
//  Purpose  : Shared defaults, counter widths and the state encoding for the
//             three-tap vertical line window.
//  Contents : DATA_W / LINE_W / LINES defaults, COL_W / ROW_W widths,
//             state_e {IDLE, FILL, RUN, FLUSH}.
//  Revision : 1.0 - initial release
// ============================================================================
package line_window_pkg;

    localparam int DATA_W = 8;
    localparam int LINE_W = 640;
    localparam int LINES  = 480;

    localparam int COL_W  = $clog2(LINE_W);
    localparam int ROW_W  = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
//  Module   : line_ram
//  Purpose  : One video line of pixel storage, single write port, read is
//             combinational from the same address.
//  Ports    : VGA_CLK  - pixel clock
//             wr_en    - write wr_data at addr on the rising edge
//             addr     - column address (read and write)
//             wr_data  - pixel to store
//             rd_data  - pixel currently stored at addr
//  Revision : 1.0 - initial release
// ============================================================================
module line_ram #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640
) (
    input  logic                      VGA_CLK,
    input  logic                      wr_en,
    input  logic [$clog2(LINE_W)-1:0] addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]         rd_data
);

    // Storage array; contents are undefined after reset by design.
    logic [DATA_W-1:0] r_mem [LINE_W];

    always_ff @(posedge VGA_CLK) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end

    // Read-before-write: this returns the old word during a write cycle.
    assign rd_data = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/line_window_3tap.sv
`default_nettype none
// ============================================================================
//  Module   : line_window_3tap
//  Purpose  : Vertical 3-tap window generator feeding the Sobel stage. Keeps
//             the two previous lines and emits (row-1, row, row+1) per column
//             with border replication and an autonomous last-line flush.
//  Ports    : VGA_CLK, RST_N (async, active low)
//             pix_in / pix_valid / sof   - raster input, sof marks (0,0)
//             in_ready                   - low only while flushing
//             prev/center/next_pixel     - window taps
//             out_valid / out_col / out_row - window qualifier and position
//  Revision : 1.0 - initial release
// ============================================================================
module line_window_3tap #(
    parameter int DATA_W = line_window_pkg::DATA_W,
    parameter int LINE_W = line_window_pkg::LINE_W,
    parameter int LINES  = line_window_pkg::LINES
) (
    input  logic                      VGA_CLK,
    input  logic                      RST_N,
    input  logic [DATA_W-1:0]         pix_in,
    input  logic                      pix_valid,
    input  logic                      sof,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         prev_pixel,
    output logic [DATA_W-1:0]         center_pixel,
    output logic [DATA_W-1:0]         next_pixel,
    output logic                      out_valid,
    output logic [$clog2(LINE_W)-1:0] out_col,
    output logic [$clog2(LINES)-1:0]  out_row
);

    import line_window_pkg::*;

    localparam int COL_W = $clog2(LINE_W);
    localparam int ROW_W = $clog2(LINES);

    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(LINES - 1);

    state_e             r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;

    logic [DATA_W-1:0]  r_prev;
    logic [DATA_W-1:0]  r_center;
    logic [DATA_W-1:0]  r_next;
    logic               r_out_valid;
    logic [COL_W-1:0]   r_out_col;
    logic [ROW_W-1:0]   r_out_row;

    logic               w_accept;
    logic               w_store;
    logic [COL_W-1:0]   w_addr;
    logic [DATA_W-1:0]  w_l0_rd;
    logic [DATA_W-1:0]  w_l1_rd;
    logic               w_col_last;
    logic               w_row_last;

    // Input is only blocked while the last line drains.
    assign in_ready   = (r_state != FLUSH);
    assign w_accept   = pix_valid && in_ready;
    // In IDLE only a start-of-frame pixel is kept; everything else is dropped.
    assign w_store    = w_accept && (sof || (r_state != IDLE));
    // A sof pixel is always column 0, whatever the counter says.
    assign w_addr     = (w_accept && sof) ? '0 : r_col;
    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_ROW_LAST);

    // L0 holds row r-1, L1 holds row r-2; each store shifts the column down.
    line_ram #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_l0 (
        .VGA_CLK (VGA_CLK),
        .wr_en   (w_store),
        .addr    (w_addr),
        .wr_data (pix_in),
        .rd_data (w_l0_rd)
    );

    line_ram #(.DATA_W(DATA_W), .LINE_W(LINE_W)) u_l1 (
        .VGA_CLK (VGA_CLK),
        .wr_en   (w_store),
        .addr    (w_addr),
        .wr_data (w_l0_rd),
        .rd_data (w_l1_rd)
    );

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_prev      <= '0;
            r_center    <= '0;
            r_next      <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
            r_out_row   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && sof) begin
                        r_col   <= COL_W'(1);
                        r_row   <= '0;
                        r_state <= FILL;
                    end
                end
                FILL, RUN: begin
                    if (w_accept) begin
                        if (sof) begin
                            // Abort: this pixel restarts the frame at (0,0).
                            r_col   <= COL_W'(1);
                            r_row   <= '0;
                            r_state <= FILL;
                        end else begin
                            if (r_state == RUN) begin
                                r_out_valid <= 1'b1;
                                r_center    <= w_l0_rd;
                                r_next      <= pix_in;
                                // Top border: row -1 replicates row 0.
                                r_prev      <= (r_row == ROW_W'(1)) ? w_l0_rd : w_l1_rd;
                                r_out_row   <= r_row - ROW_W'(1);
                                r_out_col   <= r_col;
                            end
                            if (w_col_last) begin
                                r_col <= '0;
                                if (r_state == FILL) begin
                                    r_row   <= ROW_W'(1);
                                    r_state <= RUN;
                                end else if (w_row_last) begin
                                    r_state <= FLUSH;
                                end else begin
                                    r_row <= r_row + ROW_W'(1);
                                end
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Last line: bottom border replicates the centre row.
                    r_out_valid <= 1'b1;
                    r_center    <= w_l0_rd;
                    r_next      <= w_l0_rd;
                    r_prev      <= w_l1_rd;
                    r_out_row   <= C_ROW_LAST;
                    r_out_col   <= r_col;
                    if (w_col_last) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign prev_pixel   = r_prev;
    assign center_pixel = r_center;
    assign next_pixel   = r_next;
    assign out_valid    = r_out_valid;
    assign out_col      = r_out_col;
    assign out_row      = r_out_row;

endmodule
`default_nettype wire
